rvfi_retire_tracker: RTL

- Producer side of the RVFI trace consumed by the designer-assertion instruction checkers.
- Captures per-instruction operand and memory information as instructions leave execute, and holds it in a small in-order record FIFO.
- Merges each record with writeback results on retirement.
- Emits one registered rvfi_* packet per retired instruction, with a monotonically increasing order number.

---
 rtl/rvfi_retire_tracker_pkg.sv | 51 +++++
 rtl/rvfi_retire_tracker_if.sv | 72 +++++++
 rtl/rvfi_retire_tracker_rec_fifo.sv | 68 ++++++
 rtl/rvfi_retire_tracker.sv | 129 ++++++++++++
 4 files changed

// File: rtl/rvfi_retire_tracker_pkg.sv
// Shared types for the RVFI retire tracker: the in-flight record, the
// registered packet payload and the fixed mode/order constants.
package rvfi_pkg;

  localparam int RVFI_XLEN   = 32;
  localparam int RVFI_MASK_W = RVFI_XLEN / 8;
  localparam int ORDER_W     = 64;
  localparam logic [1:0] RVFI_MODE_M = 2'b11;

  typedef struct packed {
    logic [31:0]            insn;
    logic [RVFI_XLEN-1:0]   pc;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic [RVFI_XLEN-1:0]   rs1_rdata;
    logic [RVFI_XLEN-1:0]   rs2_rdata;
    logic [RVFI_XLEN-1:0]   mem_addr;
    logic [RVFI_MASK_W-1:0] mem_rmask;
    logic [RVFI_MASK_W-1:0] mem_wmask;
    logic [RVFI_XLEN-1:0]   mem_wdata;
    logic [RVFI_XLEN-1:0]   mem_rdata;
    logic                   rdata_pending;
  } rvfi_rec_t;

  typedef struct packed {
    logic [31:0]            insn;
    logic                   trap;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic [4:0]             rd_addr;
    logic [RVFI_XLEN-1:0]   rs1_rdata;
    logic [RVFI_XLEN-1:0]   rs2_rdata;
    logic [RVFI_XLEN-1:0]   rd_wdata;
    logic [RVFI_XLEN-1:0]   pc_rdata;
    logic [RVFI_XLEN-1:0]   pc_wdata;
    logic [RVFI_XLEN-1:0]   mem_addr;
    logic [RVFI_XLEN-1:0]   mem_rdata;
    logic [RVFI_XLEN-1:0]   mem_wdata;
    logic [RVFI_MASK_W-1:0] mem_rmask;
    logic [RVFI_MASK_W-1:0] mem_wmask;
  } rvfi_pkt_t;

  function automatic rvfi_rec_t rec_load_rsp(rvfi_rec_t r, logic [RVFI_XLEN-1:0] d);
    rvfi_rec_t o;
    o               = r;
    o.mem_rdata     = d;
    o.rdata_pending = 1'b0;
    return o;
  endfunction

endpackage

// File: rtl/rvfi_retire_tracker_if.sv
// Execute/writeback inputs and rvfi_* trace outputs of the retire tracker.
// master = core side driving the pipeline signals, slave = the tracker.
interface rvfi_retire_tracker_if #(parameter int XLEN = 32);

  logic              ex_valid;
  logic              ex_ready;
  logic [31:0]       ex_insn;
  logic [XLEN-1:0]   ex_pc;
  logic [4:0]        ex_rs1_addr;
  logic [4:0]        ex_rs2_addr;
  logic [XLEN-1:0]   ex_rs1_rdata;
  logic [XLEN-1:0]   ex_rs2_rdata;
  logic [XLEN-1:0]   ex_mem_addr;
  logic [XLEN/8-1:0] ex_mem_rmask;
  logic [XLEN/8-1:0] ex_mem_wmask;
  logic [XLEN-1:0]   ex_mem_wdata;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_rdata;
  logic              wb_retire;
  logic              wb_trap;
  logic [4:0]        wb_rd_addr;
  logic [XLEN-1:0]   wb_rd_wdata;
  logic [XLEN-1:0]   wb_pc_wdata;
  logic              flush;

  logic              rvfi_valid;
  logic [63:0]       rvfi_order;
  logic [31:0]       rvfi_insn;
  logic              rvfi_trap;
  logic              rvfi_halt;
  logic              rvfi_intr;
  logic [1:0]        rvfi_mode;
  logic [4:0]        rvfi_rs1_addr;
  logic [4:0]        rvfi_rs2_addr;
  logic [4:0]        rvfi_rd_addr;
  logic [XLEN-1:0]   rvfi_rs1_rdata;
  logic [XLEN-1:0]   rvfi_rs2_rdata;
  logic [XLEN-1:0]   rvfi_rd_wdata;
  logic [XLEN-1:0]   rvfi_pc_rdata;
  logic [XLEN-1:0]   rvfi_pc_wdata;
  logic [XLEN-1:0]   rvfi_mem_addr;
  logic [XLEN-1:0]   rvfi_mem_rdata;
  logic [XLEN-1:0]   rvfi_mem_wdata;
  logic [XLEN/8-1:0] rvfi_mem_rmask;
  logic [XLEN/8-1:0] rvfi_mem_wmask;
  logic              err_underflow;

  modport master (
    output ex_valid, ex_insn, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rs1_rdata,
           ex_rs2_rdata, ex_mem_addr, ex_mem_rmask, ex_mem_wmask, ex_mem_wdata,
           mem_rsp_valid, mem_rsp_rdata, wb_retire, wb_trap, wb_rd_addr,
           wb_rd_wdata, wb_pc_wdata, flush,
    input  ex_ready, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt,
           rvfi_intr, rvfi_mode, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
           rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata,
           rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
           rvfi_mem_rmask, rvfi_mem_wmask, err_underflow
  );

  modport slave (
    input  ex_valid, ex_insn, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rs1_rdata,
           ex_rs2_rdata, ex_mem_addr, ex_mem_rmask, ex_mem_wmask, ex_mem_wdata,
           mem_rsp_valid, mem_rsp_rdata, wb_retire, wb_trap, wb_rd_addr,
           wb_rd_wdata, wb_pc_wdata, flush,
    output ex_ready, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt,
           rvfi_intr, rvfi_mode, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
           rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata,
           rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
           rvfi_mem_rmask, rvfi_mem_wmask, err_underflow
  );

endinterface

// File: rtl/rvfi_retire_tracker_rec_fifo.sv
// In-order record FIFO between execute and writeback, with a head-entry
// update port for late load data and a single-cycle flush.
module rvfi_rec_fifo
  import rvfi_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  rvfi_rec_t            push_rec_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  logic                 upd_i,
  input  logic [RVFI_XLEN-1:0] upd_rdata_i,
  output rvfi_rec_t            head_o,
  output logic                 empty_o,
  output logic                 full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          push_ok, pop_ok;
  rvfi_rec_t     mem_q [DEPTH];

  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head_o  = mem_q[rd_idx];

  // Full plus pop frees the head slot in the same edge the tail lands on it.
  assign push_ok = push_i && !flush_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Push is written last so it wins when tail and a popped head share a slot.
  always_ff @(posedge clk_i) begin
    if (upd_i && !empty_o) mem_q[rd_idx] <= rec_load_rsp(mem_q[rd_idx], upd_rdata_i);
    if (push_ok)           mem_q[wr_idx] <= push_rec_i;
  end

endmodule

// File: rtl/rvfi_retire_tracker.sv
// RVFI producer: queues execute-stage records and emits one registered
// rvfi_* packet per retirement, merged with writeback results.
module rvfi_retire_tracker
  import rvfi_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = RVFI_XLEN
) (
  input logic                 g_clk,
  input logic                 g_reset,
  rvfi_retire_tracker_if.slave bus
);

  rvfi_rec_t              head, push_rec;
  logic                   empty, full, push, pop;
  rvfi_pkt_t              pkt_q, pkt_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [ORDER_W-1:0]     order_q, order_d;
  logic [ORDER_W-1:0]     cnt_q, cnt_d;

  assign bus.ex_ready = !full || bus.wb_retire;
  assign push         = bus.ex_valid && bus.ex_ready;
  assign pop          = bus.wb_retire && !empty;

  always_comb begin
    push_rec               = '0;
    push_rec.insn          = bus.ex_insn;
    push_rec.pc            = RVFI_XLEN'(bus.ex_pc);
    push_rec.rs1_addr      = bus.ex_rs1_addr;
    push_rec.rs2_addr      = bus.ex_rs2_addr;
    push_rec.rs1_rdata     = (bus.ex_rs1_addr == 5'd0) ? '0 : RVFI_XLEN'(bus.ex_rs1_rdata);
    push_rec.rs2_rdata     = (bus.ex_rs2_addr == 5'd0) ? '0 : RVFI_XLEN'(bus.ex_rs2_rdata);
    push_rec.mem_addr      = RVFI_XLEN'(bus.ex_mem_addr);
    push_rec.mem_rmask     = RVFI_MASK_W'(bus.ex_mem_rmask);
    push_rec.mem_wmask     = RVFI_MASK_W'(bus.ex_mem_wmask);
    push_rec.mem_wdata     = RVFI_XLEN'(bus.ex_mem_wdata);
    push_rec.rdata_pending = (bus.ex_mem_rmask != '0);
  end

  rvfi_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (g_clk),
    .rst_i       (g_reset),
    .push_i      (push),
    .push_rec_i  (push_rec),
    .pop_i       (pop),
    .flush_i     (bus.flush),
    .upd_i       (bus.mem_rsp_valid),
    .upd_rdata_i (RVFI_XLEN'(bus.mem_rsp_rdata)),
    .head_o      (head),
    .empty_o     (empty),
    .full_o      (full)
  );

  always_comb begin
    pkt_d   = pkt_q;
    valid_d = pop;
    order_d = order_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (bus.wb_retire && empty) err_d = 1'b1;
    if (pop) begin
      order_d         = cnt_q;
      cnt_d           = cnt_q + 64'd1;
      pkt_d.insn      = head.insn;
      pkt_d.pc_rdata  = head.pc;
      pkt_d.pc_wdata  = RVFI_XLEN'(bus.wb_pc_wdata);
      pkt_d.rs1_addr  = head.rs1_addr;
      pkt_d.rs2_addr  = head.rs2_addr;
      pkt_d.rs1_rdata = head.rs1_rdata;
      pkt_d.rs2_rdata = head.rs2_rdata;
      pkt_d.mem_addr  = head.mem_addr;
      pkt_d.mem_wdata = head.mem_wdata;
      pkt_d.trap      = bus.wb_trap;
      pkt_d.rd_addr   = bus.wb_trap ? 5'd0 : bus.wb_rd_addr;
      pkt_d.rd_wdata  = (bus.wb_trap || bus.wb_rd_addr == 5'd0) ? '0 : RVFI_XLEN'(bus.wb_rd_wdata);
      pkt_d.mem_rmask = bus.wb_trap ? '0 : head.mem_rmask;
      pkt_d.mem_wmask = bus.wb_trap ? '0 : head.mem_wmask;
      // A same-cycle load response bypasses the FIFO; a still-missing one is an error.
      if (bus.mem_rsp_valid) begin
        pkt_d.mem_rdata = RVFI_XLEN'(bus.mem_rsp_rdata);
      end else if (head.rdata_pending) begin
        pkt_d.mem_rdata = '0;
        err_d           = 1'b1;
      end else begin
        pkt_d.mem_rdata = head.mem_rdata;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      pkt_q   <= '0;
      valid_q <= 1'b0;
      order_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
      order_q <= order_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.rvfi_valid     = valid_q;
  assign bus.rvfi_order     = order_q;
  assign bus.rvfi_insn      = pkt_q.insn;
  assign bus.rvfi_trap      = pkt_q.trap;
  assign bus.rvfi_halt      = 1'b0;
  assign bus.rvfi_intr      = 1'b0;
  assign bus.rvfi_mode      = RVFI_MODE_M;
  assign bus.rvfi_rs1_addr  = pkt_q.rs1_addr;
  assign bus.rvfi_rs2_addr  = pkt_q.rs2_addr;
  assign bus.rvfi_rd_addr   = pkt_q.rd_addr;
  assign bus.rvfi_rs1_rdata = XLEN'(pkt_q.rs1_rdata);
  assign bus.rvfi_rs2_rdata = XLEN'(pkt_q.rs2_rdata);
  assign bus.rvfi_rd_wdata  = XLEN'(pkt_q.rd_wdata);
  assign bus.rvfi_pc_rdata  = XLEN'(pkt_q.pc_rdata);
  assign bus.rvfi_pc_wdata  = XLEN'(pkt_q.pc_wdata);
  assign bus.rvfi_mem_addr  = XLEN'(pkt_q.mem_addr);
  assign bus.rvfi_mem_rdata = XLEN'(pkt_q.mem_rdata);
  assign bus.rvfi_mem_wdata = XLEN'(pkt_q.mem_wdata);
  assign bus.rvfi_mem_rmask = (XLEN/8)'(pkt_q.mem_rmask);
  assign bus.rvfi_mem_wmask = (XLEN/8)'(pkt_q.mem_wmask);
  assign bus.err_underflow  = err_q;

endmodule
